// File: rtl/membus_pkg.sv
// ---------------------------------------------------------------------------
// membus_pkg
// Shared definitions for the PDP-6 memory-bus core-memory responder.
//   state_t : responder cycle states
//   MB_W    : memory-bus data width (bits 0:35)
//   MA_W    : word-address width (bits 21:35)
//   SEL_W   : module-select width (bits 18:21)
// ---------------------------------------------------------------------------
package membus_pkg;

    localparam int MB_W  = 36;
    localparam int MA_W  = 15;
    localparam int SEL_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        READ,
        RDRS,
        RESTORE,
        WAIT_WR,
        WRITE
    } state_t;

endpackage

// File: rtl/membus_core_slave_if.sv
// ---------------------------------------------------------------------------
// membus_core_slave_if
// One memory-bus slave port.
//   master -> slave : wr_rs, rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select,
//                     mb_write
//   slave -> master : addr_ack, rd_rs, mb_read
// Slave outputs are zero when not driving so several slaves can be OR-ed.
// ---------------------------------------------------------------------------
interface membus_core_slave_if;

    logic                       wr_rs;
    logic                       rq_cyc;
    logic                       rd_rq;
    logic                       wr_rq;
    logic [membus_pkg::MA_W-1:0]  ma;
    logic [membus_pkg::SEL_W-1:0] sel;
    logic                       fmc_select;
    logic [membus_pkg::MB_W-1:0]  mb_write;
    logic                       addr_ack;
    logic                       rd_rs;
    logic [membus_pkg::MB_W-1:0]  mb_read;

    modport master (
        output wr_rs, rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select, mb_write,
        input  addr_ack, rd_rs, mb_read
    );

    modport slave (
        input  wr_rs, rq_cyc, rd_rq, wr_rq, ma, sel, fmc_select, mb_write,
        output addr_ack, rd_rs, mb_read
    );

endinterface

// File: rtl/membus_core_array.sv
// ---------------------------------------------------------------------------
// membus_core_array
// Synchronous single-port RAM, 2^ADDR_W words of DATA_W bits.
//   clk   : clock
//   we    : write enable, writes wdata at addr on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (old contents on a write cycle)
// No reset: core memory contents survive a bus reset.
// ---------------------------------------------------------------------------
module membus_core_array #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/membus_core_slave.sv
// ---------------------------------------------------------------------------
// membus_core_slave
// Core-memory responder on one slave port of the PDP-6 memory bus.
// Accepts read, write and read-modify-write cycles and models core timing
// (destructive read followed by restore) with an FSM and a latency counter.
//   clk    : clock
//   reset  : asynchronous, active-low reset (array contents kept)
//   membus : slave side of the memory bus
//   sw_sel : this module's address switches
//   busy   : 1 whenever the FSM is not IDLE
// All outputs are registered and are zero when the module is not driving.
// ---------------------------------------------------------------------------
module membus_core_slave
    import membus_pkg::*;
#(
    parameter int MEM_BITS = 14,
    parameter int RD_DLY   = 4,
    parameter int WR_DLY   = 4
) (
    input  logic               clk,
    input  logic               reset,
    membus_core_slave_if.slave membus,
    input  logic [SEL_W-1:0]   sw_sel,
    output logic               busy
);

    localparam int MAX_DLY = (RD_DLY > WR_DLY) ? RD_DLY : WR_DLY;
    localparam int CNT_W   = ($clog2(MAX_DLY) > 0) ? $clog2(MAX_DLY) : 1;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [MEM_BITS-1:0] idx;
    logic                rd_f;
    logic                wr_f;
    logic [MB_W-1:0]     wdata;
    logic [MB_W-1:0]     rdata;
    logic                accept;
    logic                rd_last;
    logic                wr_last;
    logic                array_we;

    assign accept = membus.rq_cyc & (membus.rd_rq | membus.wr_rq) &
                    ~membus.fmc_select & (membus.sel == sw_sel);

    assign rd_last  = (cnt == CNT_W'(RD_DLY - 1));
    assign wr_last  = (cnt == CNT_W'(WR_DLY - 1));
    assign array_we = (state == WRITE) && wr_last;

    // The array reads idx every cycle, so by the last READ cycle rdata already
    // holds the word and can be loaded straight into the mb_read register.
    // Restore would write back identical data, so it issues no write.
    membus_core_array #(
        .ADDR_W (MEM_BITS),
        .DATA_W (MB_W)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .addr  (idx),
        .wdata (wdata),
        .rdata (rdata)
    );

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)         state_nx = ACK;
            ACK:     if (!membus.rq_cyc) state_nx = rd_f ? READ : WAIT_WR;
            READ:    if (rd_last)        state_nx = RDRS;
            RDRS:                        state_nx = wr_f ? WAIT_WR : RESTORE;
            RESTORE: if (wr_last)        state_nx = IDLE;
            WAIT_WR: if (membus.wr_rs)   state_nx = WRITE;
            WRITE:   if (wr_last)        state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    // State, latency counter and registered outputs. Outputs are decoded from
    // the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            membus.addr_ack <= 1'b0;
            membus.rd_rs   <= 1'b0;
            membus.mb_read <= '0;
            busy           <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            membus.addr_ack <= (state_nx == ACK);
            membus.rd_rs   <= (state_nx == RDRS);
            membus.mb_read <= (state_nx == RDRS) ? rdata : '0;
            busy           <= (state_nx != IDLE);
        end
    end

    // Cycle parameters are latched so later bus changes cannot disturb a
    // cycle in progress.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            idx  <= membus.ma[MEM_BITS-1:0];
            rd_f <= membus.rd_rq;
            wr_f <= membus.wr_rq;
        end
        if (state == WAIT_WR && membus.wr_rs) begin
            wdata <= membus.mb_write;
        end
    end

endmodule

// File: tb/tb_membus_core_slave.sv
// ---------------------------------------------------------------------------
// tb_membus_core_slave
// Self-checking bench for membus_core_slave: directed bus cycles, a read
// scoreboard checked on every rd_rs, and cycle-accurate timing checks.
// ---------------------------------------------------------------------------
module tb_membus_core_slave;

    localparam int         MEM_BITS = 14;
    localparam int         RD_DLY   = 4;
    localparam int         WR_DLY   = 4;
    localparam logic [3:0] SW_SEL   = 4'h2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_sel;
    logic       busy;

    membus_core_slave_if membus();

    membus_core_slave #(
        .MEM_BITS (MEM_BITS),
        .RD_DLY   (RD_DLY),
        .WR_DLY   (WR_DLY)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .membus (membus),
        .sw_sel (sw_sel),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks      = 0;
    int          errors      = 0;
    int          rd_rs_count = 0;
    int          last_ack_cyc;
    int          rd_rs_cyc;
    logic [35:0] sb [$];
    logic [35:0] model_mem [int];

    task automatic checkOutput(input string tag, input logic [35:0] obs,
                               input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [14:0] ma);
        return int'(ma[MEM_BITS-1:0]);
    endfunction

    task automatic applyStimulus(input logic rq, input logic rd, input logic wr,
                                 input logic [14:0] ma, input logic [3:0] sel,
                                 input logic fmc);
        membus.rq_cyc     = rq;
        membus.rd_rq      = rd;
        membus.wr_rq      = wr;
        membus.ma         = ma;
        membus.sel        = sel;
        membus.fmc_select = fmc;
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        @(negedge clk);
        while (membus.addr_ack !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        last_ack_cyc = cyc;
        checkOutput(tag, 36'(membus.addr_ack), 36'd1);
    endtask

    task automatic wait_rd_rs(input string tag);
        int n = 0;
        @(negedge clk);
        while (membus.rd_rs !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        rd_rs_cyc = cyc;
        checkOutput(tag, 36'(membus.rd_rs), 36'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 36'(busy), 36'd0);
    endtask

    // One complete master cycle; address is scrambled after accept to show
    // the slave works from its latched copy.
    task automatic do_cycle(input logic rd, input logic wr, input logic [14:0] ma,
                            input logic [35:0] wdata);
        @(negedge clk);
        applyStimulus(1'b1, rd, wr, ma, SW_SEL, 1'b0);
        if (rd) sb.push_back(model_mem[idx_of(ma)]);
        wait_ack("ack");
        applyStimulus(1'b0, 1'b0, 1'b0, ~ma, SW_SEL, 1'b0);
        if (rd) wait_rd_rs("rd_rs");
        if (wr) begin
            @(negedge clk);
            membus.wr_rs    = 1'b1;
            membus.mb_write = wdata;
            @(negedge clk);
            membus.wr_rs    = 1'b0;
            membus.mb_write = '0;
            model_mem[idx_of(ma)] = wdata;
        end
        wait_idle("idle");
    endtask

    // Scoreboard monitor: every rd_rs must match the oldest expected read,
    // and mb_read must be zero on every other cycle.
    always @(negedge clk) begin : monitor
        logic [35:0] exp_word;
        if (reset === 1'b1) begin
            if (membus.rd_rs === 1'b1) begin
                rd_rs_count++;
                if (sb.size() == 0) begin
                    checkOutput("rd_rs_unexpected", 36'(membus.rd_rs), 36'd0);
                end else begin
                    exp_word = sb.pop_front();
                    checkOutput("mb_read", membus.mb_read, exp_word);
                end
            end else begin
                checkOutput("mb_read_idle", membus.mb_read, 36'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int   n0;
        int   r;
        int   idle_cyc;
        int   ack_cyc;
        logic early;
        logic seen_ack;
        logic seen_rs;
        logic seen_busy;

        reset           = 1'b0;
        sw_sel          = SW_SEL;
        membus.wr_rs    = 1'b0;
        membus.mb_write = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, 4'h0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_addr_ack", 36'(membus.addr_ack), 36'd0);
        checkOutput("rst_rd_rs", 36'(membus.rd_rs), 36'd0);
        checkOutput("rst_mb_read", membus.mb_read, 36'd0);
        checkOutput("rst_busy", 36'(busy), 36'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write then read
        $display("[TB] write then read");
        n0 = rd_rs_count;
        do_cycle(1'b0, 1'b1, 15'o01234, 36'o123456701234);
        checkOutput("wo_no_rd_rs", 36'(rd_rs_count - n0), 36'd0);
        n0 = rd_rs_count;
        do_cycle(1'b1, 1'b0, 15'o01234, 36'd0);
        checkOutput("rd_one_rd_rs", 36'(rd_rs_count - n0), 36'd1);
        checkOutput("rd_latency", 36'(rd_rs_cyc - last_ack_cyc), 36'(RD_DLY + 1));

        // Read-modify-write
        $display("[TB] read-modify-write");
        do_cycle(1'b0, 1'b1, 15'o02000, 36'o5);
        n0 = rd_rs_count;
        do_cycle(1'b1, 1'b1, 15'o02000, 36'o6);
        checkOutput("rmw_one_rd_rs", 36'(rd_rs_count - n0), 36'd1);
        checkOutput("rmw_latency", 36'(rd_rs_cyc - last_ack_cyc), 36'(RD_DLY + 1));
        do_cycle(1'b1, 1'b0, 15'o02000, 36'd0);

        // Non-selection: wrong sel, then fast memory selected
        $display("[TB] non-selection");
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b1, 1'b1, 15'o01234, (v == 0) ? 4'h3 : SW_SEL, v == 1);
            seen_ack  = 1'b0;
            seen_rs   = 1'b0;
            seen_busy = 1'b0;
            repeat (50) begin
                @(negedge clk);
                seen_ack  = seen_ack  | membus.addr_ack;
                seen_rs   = seen_rs   | membus.rd_rs;
                seen_busy = seen_busy | busy;
            end
            checkOutput("nosel_addr_ack", 36'(seen_ack), 36'd0);
            checkOutput("nosel_rd_rs", 36'(seen_rs), 36'd0);
            checkOutput("nosel_busy", 36'(seen_busy), 36'd0);
            applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, SW_SEL, 1'b0);
        end

        // Busy collision: second request raised during RESTORE
        $display("[TB] busy collision");
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 15'o01234, SW_SEL, 1'b0);
        sb.push_back(model_mem[idx_of(15'o01234)]);
        wait_ack("col_ack1");
        applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, SW_SEL, 1'b0);
        wait_rd_rs("col_rd_rs1");
        r = rd_rs_cyc;
        @(negedge clk);
        checkOutput("col_restore_busy", 36'(busy), 36'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 15'o02000, SW_SEL, 1'b0);
        sb.push_back(model_mem[idx_of(15'o02000)]);
        idle_cyc = -1;
        ack_cyc  = -1;
        early    = 1'b0;
        for (int n = 0; n < 30 && ack_cyc < 0; n++) begin
            @(negedge clk);
            if (membus.addr_ack === 1'b1) begin
                ack_cyc = cyc;
                if (idle_cyc < 0) early = 1'b1;
            end else if (busy === 1'b0 && idle_cyc < 0) begin
                idle_cyc = cyc;
            end
        end
        checkOutput("col_no_early_ack", 36'(early), 36'd0);
        checkOutput("col_idle_time", 36'(idle_cyc - r), 36'(WR_DLY + 1));
        checkOutput("col_ack_after_idle", 36'(ack_cyc - idle_cyc), 36'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, SW_SEL, 1'b0);
        wait_rd_rs("col_rd_rs2");
        checkOutput("col_latency2", 36'(rd_rs_cyc - ack_cyc), 36'(RD_DLY + 1));
        wait_idle("col_idle2");

        // Reset in WAIT_WR abandons the write
        $display("[TB] reset mid WAIT_WR");
        do_cycle(1'b0, 1'b1, 15'o03333, 36'o7);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1, 15'o03333, SW_SEL, 1'b0);
        wait_ack("rst_mid_ack");
        applyStimulus(1'b0, 1'b0, 1'b0, 15'd0, SW_SEL, 1'b0);
        membus.mb_write = 36'o777;
        @(negedge clk);
        checkOutput("rst_mid_busy_before", 36'(busy), 36'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 36'(busy), 36'd0);
        checkOutput("rst_mid_addr_ack", 36'(membus.addr_ack), 36'd0);
        checkOutput("rst_mid_rd_rs", 36'(membus.rd_rs), 36'd0);
        checkOutput("rst_mid_mb_read", membus.mb_read, 36'd0);
        @(negedge clk);
        reset = 1'b1;
        // wr_rs in IDLE must be ignored
        @(negedge clk);
        membus.wr_rs = 1'b1;
        @(negedge clk);
        membus.wr_rs    = 1'b0;
        membus.mb_write = '0;
        checkOutput("idle_wr_rs_busy", 36'(busy), 36'd0);
        do_cycle(1'b1, 1'b0, 15'o03333, 36'd0);

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", 36'(sb.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
